// File: rtl/alu_cu_pkg.sv
// Shared opcodes, FSM state encoding and opcode-class helpers for the ALU control unit.
package alu_cu_pkg;

    localparam int OP_W   = 6;
    localparam int DATA_W = 32;
    localparam int REG_AW = 3;

    localparam logic [OP_W-1:0] OP_LDI = 6'b000001;
    localparam logic [OP_W-1:0] OP_ADD = 6'b010000;
    localparam logic [OP_W-1:0] OP_SUB = 6'b010001;
    localparam logic [OP_W-1:0] OP_EQ  = 6'b100000;
    localparam logic [OP_W-1:0] OP_NE  = 6'b100001;
    localparam logic [OP_W-1:0] OP_LE  = 6'b100010;
    localparam logic [OP_W-1:0] OP_GT  = 6'b100011;
    localparam logic [OP_W-1:0] OP_SHL = 6'b110000;
    localparam logic [OP_W-1:0] OP_SHR = 6'b110001;
    localparam logic [OP_W-1:0] OP_SRA = 6'b110010;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_WB
    } state_t;

    // Opcodes that are routed through the external ALU.
    function automatic logic is_alu_op(input logic [OP_W-1:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_EQ, OP_NE, OP_LE, OP_GT,
            OP_SHL, OP_SHR, OP_SRA: is_alu_op = 1'b1;
            default:                is_alu_op = 1'b0;
        endcase
    endfunction

    // Only add/subtract produce a meaningful carry/borrow.
    function automatic logic is_arith_op(input logic [OP_W-1:0] op);
        is_arith_op = (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_cu_regfile.sv
// Register file: two asynchronous read ports, one synchronous write port, r0 fixed at zero.
module alu_cu_regfile #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] ra1,
    input  logic [REG_AW-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    input  logic              we,
    input  logic [REG_AW-1:0] wa,
    input  logic [DATA_W-1:0] wd
);

    localparam int NREG = 1 << REG_AW;

    logic [NREG-1:0][DATA_W-1:0] regs;

    // Write port; writes to r0 are dropped so it always stays zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs <= '0;
        end else if (we && (wa != '0)) begin
            regs[wa] <= wd;
        end
    end

    assign rd1 = (ra1 == '0) ? '0 : regs[ra1];
    assign rd2 = (ra2 == '0) ? '0 : regs[ra2];

endmodule

// File: rtl/alu_cu_sequencer.sv
// Three-state control unit: accept an instruction, drive the external ALU, write back and retire.
import alu_cu_pkg::*;

module alu_cu_sequencer #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 3,
    parameter int OP_W   = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [OP_W-1:0]   instr_op,
    input  logic [REG_AW-1:0] instr_rd,
    input  logic [REG_AW-1:0] instr_rs1,
    input  logic [REG_AW-1:0] instr_rs2,
    input  logic [DATA_W-1:0] instr_imm,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    input  logic [DATA_W-1:0] alu_res,
    input  logic              alu_cout,
    input  logic              alu_z,
    input  logic              alu_n,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              flag_c,
    output logic              flag_z,
    output logic              flag_n,
    output logic              illegal
);

    state_t            state;
    logic [OP_W-1:0]   op_q;
    logic [REG_AW-1:0] rd_q;
    logic [DATA_W-1:0] imm_q;
    logic [DATA_W-1:0] res_q;
    logic              cout_q;
    logic              z_q;
    logic              n_q;

    logic [DATA_W-1:0] rs1_data;
    logic [DATA_W-1:0] rs2_data;
    logic              wb_en;
    logic [DATA_W-1:0] wb_data;

    assign instr_ready = (state == ST_IDLE);
    assign wb_en       = (state == ST_WB) && (is_alu_op(op_q) || (op_q == OP_LDI));
    assign wb_data     = (op_q == OP_LDI) ? imm_q : res_q;

    alu_cu_regfile #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
    ) u_rf (
        .clk   (clk),
        .rst_n (rst_n),
        .ra1   (instr_rs1),
        .ra2   (instr_rs2),
        .rd1   (rs1_data),
        .rd2   (rs2_data),
        .we    (wb_en),
        .wa    (rd_q),
        .wd    (wb_data)
    );

    // Sequencer FSM; operands are captured at accept, so rs==rd reads the old value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            op_q    <= '0;
            rd_q    <= '0;
            imm_q   <= '0;
            res_q   <= '0;
            cout_q  <= 1'b0;
            z_q     <= 1'b0;
            n_q     <= 1'b0;
            alu_a   <= '0;
            alu_b   <= '0;
            alu_op  <= '0;
            done    <= 1'b0;
            illegal <= 1'b0;
            result  <= '0;
            flag_c  <= 1'b0;
            flag_z  <= 1'b0;
            flag_n  <= 1'b0;
        end else begin
            done    <= 1'b0;
            illegal <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (instr_valid) begin
                        op_q  <= instr_op;
                        rd_q  <= instr_rd;
                        imm_q <= instr_imm;
                        alu_a <= rs1_data;
                        alu_b <= rs2_data;
                        if (is_alu_op(instr_op)) alu_op <= instr_op;
                        state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    res_q  <= alu_res;
                    cout_q <= alu_cout;
                    z_q    <= alu_z;
                    n_q    <= alu_n;
                    state  <= ST_WB;
                end
                ST_WB: begin
                    done <= 1'b1;
                    if (is_alu_op(op_q)) begin
                        result <= res_q;
                        flag_z <= z_q;
                        flag_n <= n_q;
                        if (is_arith_op(op_q)) flag_c <= cout_q;
                    end else if (op_q == OP_LDI) begin
                        result <= imm_q;
                    end else begin
                        result  <= '0;
                        illegal <= 1'b1;
                    end
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
